// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer.
// Holds the sequencer state encoding and the width of the 8-bit
// retry/loss event counters.
package pll_seq_pkg;

  localparam int STATE_W = 3;
  localparam int CNT8_W  = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } seqState_t;

endpackage

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
// Ports:
//   clk     - destination domain clock
//   reset_n - asynchronous active-low reset, clears both flops to 0
//   d_i     - asynchronous input level
//   q_o     - synchronized level, valid two edges after d_i changes
module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // First flop may go metastable; the second gives it a full cycle to settle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer, reference-clock domain.
// Holds the PLL in reset, waits for a qualified lock, then releases the
// downstream reset request. Retries on lock timeout, re-sequences when lock
// drops while running, and parks in a failure state after too many retries.
// Ports:
//   clk         - reference clock (also the PLL refclk)
//   reset_n     - asynchronous active-low reset
//   restart     - one-cycle pulse, forces a fresh sequence from any state
//   locked      - PLL lock indicator, asynchronous to clk
//   pll_rst     - PLL reset, active high
//   sys_reset_n - downstream reset request, active low
//   ready       - high while running
//   fail        - high in the terminal failure state
//   lock_lost   - one-cycle pulse when lock drops while running
//   retry_count - lock timeouts since the last restart or run entry
//   loss_count  - lock-loss events since reset_n, saturating
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 4,
  parameter int CNT_W         = 17
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              restart,
  input  logic              locked,
  output logic              pll_rst,
  output logic              sys_reset_n,
  output logic              ready,
  output logic              fail,
  output logic              lock_lost,
  output logic [CNT8_W-1:0] retry_count,
  output logic [CNT8_W-1:0] loss_count
);

  localparam logic [CNT_W-1:0]  RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT8_W-1:0] RETRY_LIMIT = CNT8_W'(MAX_RETRIES);

  seqState_t         state_q, state_d;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic [CNT8_W-1:0] retry_q, retry_d;
  logic [CNT8_W-1:0] loss_q, loss_d;
  logic              pllRst_q, pllRst_d;
  logic              sysResetN_q, sysResetN_d;
  logic              ready_q, ready_d;
  logic              fail_q, fail_d;
  logic              lockLost_q, lockLost_d;
  logic              lockedS;
  logic              lossEvent;

  sync_2ff u_lockSync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (locked),
    .q_o     (lockedS)
  );

  // A lock drop while running counts as a loss only when restart is not
  // overriding it on the same edge
  assign lossEvent = !restart && (state_q == ST_RUN) && !lockedS;

  // State register plus timer, counters and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_RESET;
      timer_q     <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      pllRst_q    <= 1'b1;
      sysResetN_q <= 1'b0;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
      lockLost_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      pllRst_q    <= pllRst_d;
      sysResetN_q <= sysResetN_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
      lockLost_q  <= lockLost_d;
    end
  end

  // Next-state logic; lock is tested before the timeout so a lock arriving
  // on the last timeout cycle still wins
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    if (restart) begin
      state_d = ST_RESET;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_RESET: begin
          if (timer_q == RST_LAST) state_d = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (lockedS) begin
            state_d = ST_STABLE;
          end else if (timer_q == LOCK_LAST) begin
            retry_d = retry_q + CNT8_W'(1);
            state_d = (retry_d == RETRY_LIMIT) ? ST_FAIL : ST_RESET;
          end
        end
        ST_STABLE: begin
          if (!lockedS) begin
            state_d = ST_WAIT_LOCK;
          end else if (timer_q == STABLE_LAST) begin
            state_d = ST_RUN;
            retry_d = '0;
          end
        end
        ST_RUN: begin
          if (!lockedS) state_d = ST_RESET;
        end
        ST_FAIL: state_d = ST_FAIL;
        default: state_d = ST_RESET;
      endcase
    end
  end

  // Timer restarts on every state change and only runs in the timed states,
  // so it can never wrap while parked in RUN or FAIL
  always_comb begin
    timer_d = timer_q;
    if (restart || (state_d != state_q)) begin
      timer_d = '0;
    end else if ((state_q == ST_RESET) || (state_q == ST_WAIT_LOCK) ||
                 (state_q == ST_STABLE)) begin
      timer_d = timer_q + CNT_W'(1);
    end
  end

  // Output logic derived from the next state so every output is registered
  // and changes on the same edge as the state
  always_comb begin
    pllRst_d    = (state_d == ST_RESET) || (state_d == ST_FAIL);
    sysResetN_d = (state_d == ST_RUN);
    ready_d     = (state_d == ST_RUN);
    fail_d      = (state_d == ST_FAIL);
    lockLost_d  = lossEvent;
    loss_d      = loss_q;
    if (lossEvent && (loss_q != '1)) loss_d = loss_q + CNT8_W'(1);
  end

  assign pll_rst     = pllRst_q;
  assign sys_reset_n = sysResetN_q;
  assign ready       = ready_q;
  assign fail        = fail_q;
  assign lock_lost   = lockLost_q;
  assign retry_count = retry_q;
  assign loss_count  = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed testbench for pll_reset_sequencer with small timing parameters.
module tb_pll_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       restart;
  logic       locked;
  logic       pll_rst;
  logic       sys_reset_n;
  logic       ready;
  logic       fail;
  logic       lock_lost;
  logic [7:0] retry_count;
  logic [7:0] loss_count;

  int totalChecks = 0;
  int badChecks   = 0;

  pll_reset_sequencer #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (16),
    .STABLE_CYCLES (8),
    .MAX_RETRIES   (3),
    .CNT_W         (17)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .restart     (restart),
    .locked      (locked),
    .pll_rst     (pll_rst),
    .sys_reset_n (sys_reset_n),
    .ready       (ready),
    .fail        (fail),
    .lock_lost   (lock_lost),
    .retry_count (retry_count),
    .loss_count  (loss_count)
  );

  // 50 MHz reference clock
  always #10 clk = ~clk;

  // Drive all inputs at once
  task automatic applyStimulus(input logic rstN, input logic rs, input logic lk);
    reset_n = rstN;
    restart = rs;
    locked  = lk;
  endtask

  // Advance n rising edges and settle on the following falling edge
  task automatic waitEdges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Count a comparison and report it if it does not match
  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);

    // Reset state
    checkOutput("rst_pll_rst", pll_rst, 8'd1);
    checkOutput("rst_sysrstn", sys_reset_n, 8'd0);
    checkOutput("rst_ready", ready, 8'd0);
    checkOutput("rst_fail", fail, 8'd0);
    checkOutput("rst_lock_lost", lock_lost, 8'd0);
    checkOutput("rst_retry", retry_count, 8'd0);
    checkOutput("rst_loss", loss_count, 8'd0);

    // Startup: pll_rst high for exactly 4 edges, lock 5 cycles later
    $display("[TB] startup sequence");
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitEdges(3);
    checkOutput("t1_pll_rst_hi", pll_rst, 8'd1);
    waitEdges(1);
    checkOutput("t1_pll_rst_lo", pll_rst, 8'd0);
    waitEdges(5);
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitEdges(10);
    checkOutput("t1_ready_early", ready, 8'd0);
    checkOutput("t1_sysrstn_early", sys_reset_n, 8'd0);
    waitEdges(1);
    checkOutput("t1_ready", ready, 8'd1);
    checkOutput("t1_sysrstn", sys_reset_n, 8'd1);
    checkOutput("t1_retry", retry_count, 8'd0);

    // Lock loss in RUN, then re-lock
    $display("[TB] lock loss in run");
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitEdges(2);
    checkOutput("t3_ready_hold", ready, 8'd1);
    checkOutput("t3_no_pulse_yet", lock_lost, 8'd0);
    waitEdges(1);
    checkOutput("t3_lock_lost", lock_lost, 8'd1);
    checkOutput("t3_sysrstn", sys_reset_n, 8'd0);
    checkOutput("t3_ready", ready, 8'd0);
    checkOutput("t3_pll_rst", pll_rst, 8'd1);
    checkOutput("t3_loss", loss_count, 8'd1);
    waitEdges(1);
    checkOutput("t3_pulse_end", lock_lost, 8'd0);
    waitEdges(2);
    checkOutput("t3_pll_rst_hi", pll_rst, 8'd1);
    waitEdges(1);
    checkOutput("t3_pll_rst_lo", pll_rst, 8'd0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitEdges(10);
    checkOutput("t3_ready_early", ready, 8'd0);
    waitEdges(1);
    checkOutput("t3_ready_again", ready, 8'd1);

    // Lock glitch during STABLE falls back to WAIT_LOCK without a retry
    $display("[TB] lock glitch in stable");
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitEdges(3);
    checkOutput("t4_loss", loss_count, 8'd2);
    waitEdges(4);
    checkOutput("t4_wait_lock", pll_rst, 8'd0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitEdges(8);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitEdges(3);
    checkOutput("t4_no_ready", ready, 8'd0);
    checkOutput("t4_retry", retry_count, 8'd0);
    checkOutput("t4_pll_rst", pll_rst, 8'd0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitEdges(10);
    checkOutput("t4_ready_early", ready, 8'd0);
    waitEdges(1);
    checkOutput("t4_ready", ready, 8'd1);
    checkOutput("t4_retry_run", retry_count, 8'd0);

    // Lock never returns: three timeouts, then FAIL
    $display("[TB] timeouts to fail");
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitEdges(3);
    checkOutput("t2_loss", loss_count, 8'd3);
    waitEdges(4);
    checkOutput("t2_wait1", pll_rst, 8'd0);
    waitEdges(15);
    checkOutput("t2_retry0", retry_count, 8'd0);
    checkOutput("t2_pll_lo0", pll_rst, 8'd0);
    waitEdges(1);
    checkOutput("t2_retry1", retry_count, 8'd1);
    checkOutput("t2_pll_hi1", pll_rst, 8'd1);
    waitEdges(3);
    checkOutput("t2_pll_hold1", pll_rst, 8'd1);
    waitEdges(1);
    checkOutput("t2_pll_lo1", pll_rst, 8'd0);
    waitEdges(16);
    checkOutput("t2_retry2", retry_count, 8'd2);
    checkOutput("t2_pll_hi2", pll_rst, 8'd1);
    checkOutput("t2_fail_no", fail, 8'd0);
    waitEdges(4);
    checkOutput("t2_pll_lo2", pll_rst, 8'd0);
    waitEdges(15);
    checkOutput("t2_fail_early", fail, 8'd0);
    waitEdges(1);
    checkOutput("t2_fail", fail, 8'd1);
    checkOutput("t2_retry3", retry_count, 8'd3);
    checkOutput("t2_pll_fail", pll_rst, 8'd1);
    checkOutput("t2_sysrstn", sys_reset_n, 8'd0);
    waitEdges(40);
    checkOutput("t2_fail_hold", fail, 8'd1);
    checkOutput("t2_pll_hold", pll_rst, 8'd1);
    checkOutput("t2_retry_hold", retry_count, 8'd3);

    // Restart out of FAIL
    $display("[TB] restart from fail");
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitEdges(1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t5_fail", fail, 8'd0);
    checkOutput("t5_retry", retry_count, 8'd0);
    checkOutput("t5_pll_rst", pll_rst, 8'd1);
    waitEdges(3);
    checkOutput("t5_pll_hold", pll_rst, 8'd1);
    waitEdges(1);
    checkOutput("t5_pll_lo", pll_rst, 8'd0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitEdges(11);
    checkOutput("t5_ready", ready, 8'd1);

    // Asynchronous reset in RUN
    $display("[TB] async reset");
    checkOutput("t6_loss_before", loss_count, 8'd3);
    #3;
    reset_n = 1'b0;
    #1;
    checkOutput("t6_run_pll", pll_rst, 8'd1);
    checkOutput("t6_run_ready", ready, 8'd0);
    checkOutput("t6_run_sysrstn", sys_reset_n, 8'd0);
    checkOutput("t6_run_loss", loss_count, 8'd0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b1);
    // RESET for 4 edges, STABLE entered at edge 5; edge 8 is mid-STABLE
    waitEdges(8);
    checkOutput("t6_in_stable_pll", pll_rst, 8'd0);
    checkOutput("t6_in_stable_rdy", ready, 8'd0);
    #3;
    reset_n = 1'b0;
    #1;
    checkOutput("t6_stb_pll", pll_rst, 8'd1);
    checkOutput("t6_stb_retry", retry_count, 8'd0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitEdges(13);
    checkOutput("t6_ready", ready, 8'd1);

    // Restart coincident with the FSM seeing lock loss in RUN
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitEdges(2);
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitEdges(1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t6_co_lock_lost", lock_lost, 8'd0);
    checkOutput("t6_co_loss", loss_count, 8'd0);
    checkOutput("t6_co_ready", ready, 8'd0);
    checkOutput("t6_co_pll", pll_rst, 8'd1);
    waitEdges(1);
    checkOutput("t6_co_lock_lost2", lock_lost, 8'd0);
    checkOutput("t6_co_loss2", loss_count, 8'd0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
